uart_rx_rr_collector: RTL and testbench

UART_RX_RR_COLLECTOR -- requirements
Module: uart_rx_rr_collector

---
 rtl/uart_ctrl_pkg.sv | 16 +
 rtl/uart_rr_arbiter.sv | 41 ++++
 rtl/uart_rx_rr_collector.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_rr_collector.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART RX round-robin collector.
// Holds the collector FSM encoding and channel sizing constants.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_OUT  = 2'd3
    } rx_state_t;

    localparam int UART_NUM_DEF  = 6;
    localparam int BURST_MAX_DEF = 16;
    localparam int CH_W_DEF      = $clog2(UART_NUM_DEF);

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin pick: first requesting index cyclically after the last grant.
// Purely combinational; the caller registers the result.
module uart_rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N    = UART_NUM_DEF,
    parameter int CH_W = CH_W_DEF
) (
    input  logic [N-1:0]    i_req,
    input  logic [CH_W-1:0] i_last_grant,
    output logic [CH_W-1:0] o_grant,
    output logic            o_any
);

    logic            w_hi_found;
    logic [CH_W-1:0] w_hi_grant;
    logic            w_lo_found;
    logic [CH_W-1:0] w_lo_grant;

    // Descending scan so the lowest index wins in each half.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_grant = '0;
        w_lo_found = 1'b0;
        w_lo_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_found = 1'b1;
                w_lo_grant = CH_W'(i);
                if (i > int'(i_last_grant)) begin
                    w_hi_found = 1'b1;
                    w_hi_grant = CH_W'(i);
                end
            end
        end
    end

    assign o_any   = w_lo_found;
    assign o_grant = w_hi_found ? w_hi_grant : w_lo_grant;

endmodule

// File: rtl/uart_rx_rr_collector.sv
// Round-robin collector draining per-channel UART RX FIFOs into one stream.
// Define UART_RX_BYTE_CNT_EN to add per-channel delivered-byte counters.
module uart_rx_rr_collector
    import uart_ctrl_pkg::*;
#(
    parameter int UART_NUM  = UART_NUM_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int CH_W      = CH_W_DEF
) (
    input  logic                  pcie_axi_clk,
    input  logic                  sys_reset_n,
    input  logic [UART_NUM-1:0]   fifo_uart_rx_empty,
    output logic [UART_NUM-1:0]   fifo_uart_rx_rden,
    input  logic [UART_NUM*8-1:0] uart_rx_data,
    input  logic [UART_NUM-1:0]   ch_enable,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_data,
    output logic [CH_W-1:0]       m_chan,
    output logic                  m_last,
`ifdef UART_RX_BYTE_CNT_EN
    output logic                  busy,
    output logic [UART_NUM*32-1:0] byte_cnt
`else
    output logic                  busy
`endif
);

    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic [CH_W-1:0] r_grant;
    logic [CH_W-1:0] r_last_grant;
    logic [7:0]      r_burst_cnt;
    logic [7:0]      r_data;
    logic [CH_W-1:0] r_chan;
    logic            r_last;

    logic [UART_NUM-1:0] w_eligible;
    logic [CH_W-1:0]     w_arb_grant;
    logic                w_arb_any;
    logic [7:0]          w_rx_byte;
    logic                w_empty_g;
    logic                w_en_g;
    logic                w_last_cap;
    logic                w_hs;

    assign w_eligible = ch_enable & ~fifo_uart_rx_empty;

    uart_rr_arbiter #(
        .N    (UART_NUM),
        .CH_W (CH_W)
    ) u_arb (
        .i_req        (w_eligible),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_any        (w_arb_any)
    );

    always_comb begin
        w_rx_byte = '0;
        w_empty_g = 1'b1;
        w_en_g    = 1'b0;
        for (int i = 0; i < UART_NUM; i++) begin
            if (r_grant == CH_W'(i)) begin
                w_rx_byte = uart_rx_data[i*8 +: 8];
                w_empty_g = fifo_uart_rx_empty[i];
                w_en_g    = ch_enable[i];
            end
        end
    end

    assign w_last_cap = ({1'b0, r_burst_cnt} + 9'd1 == 9'(BURST_MAX))
                      | w_empty_g | ~w_en_g;

    // Read strobe is gated by reset and by the FIFO's own empty flag.
    always_comb begin
        fifo_uart_rx_rden = '0;
        for (int i = 0; i < UART_NUM; i++) begin
            if (r_state == ST_RD && sys_reset_n &&
                r_grant == CH_W'(i) && !fifo_uart_rx_empty[i]) begin
                fifo_uart_rx_rden[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge pcie_axi_clk) begin
        if (!sys_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD:   w_state_nxt = ST_CAP;
            ST_CAP:  w_state_nxt = ST_OUT;
            ST_OUT: begin
                if (m_ready) begin
                    w_state_nxt = r_last ? ST_IDLE : ST_RD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_hs = (r_state == ST_OUT) && m_ready;

    always_ff @(posedge pcie_axi_clk) begin
        if (!sys_reset_n) begin
            r_grant      <= '0;
            r_last_grant <= CH_W'(UART_NUM - 1);
            r_burst_cnt  <= '0;
            r_data       <= '0;
            r_chan       <= '0;
            r_last       <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_arb_any) begin
                r_grant <= w_arb_grant;
            end
            if (r_state == ST_CAP) begin
                r_data      <= w_rx_byte;
                r_chan      <= r_grant;
                r_burst_cnt <= r_burst_cnt + 8'd1;
                r_last      <= w_last_cap;
            end
            if (w_hs && r_last) begin
                r_last_grant <= r_grant;
                r_burst_cnt  <= '0;
            end
        end
    end

    assign m_valid = (r_state == ST_OUT);
    assign m_data  = r_data;
    assign m_chan  = r_chan;
    assign m_last  = r_last;
    assign busy    = (r_state != ST_IDLE);

`ifdef UART_RX_BYTE_CNT_EN
    logic [31:0] r_byte_cnt [UART_NUM];

    always_ff @(posedge pcie_axi_clk) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < UART_NUM; i++) begin
                r_byte_cnt[i] <= '0;
            end
        end else if (w_hs) begin
            for (int i = 0; i < UART_NUM; i++) begin
                if (r_chan == CH_W'(i)) begin
                    r_byte_cnt[i] <= r_byte_cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < UART_NUM; g++) begin : g_cnt
        assign byte_cnt[g*32 +: 32] = r_byte_cnt[g];
    end
`endif

endmodule

// File: tb/tb_uart_rx_rr_collector.sv
// Directed-plus-random bench for uart_rx_rr_collector.
// FIFOs and expected byte order come from a queue-based reference model.
module tb_uart_rx_rr_collector;

    localparam int N  = 6;
    localparam int BM = 16;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   empty = '1;
    logic [N-1:0]   rden;
    logic [N*8-1:0] rx_data = '0;
    logic [N-1:0]   en;
    logic           m_valid;
    logic           m_ready;
    logic [7:0]     m_data;
    logic [CW-1:0]  m_chan;
    logic           m_last;
    logic           busy;

    logic [7:0]  q[N][$];
    logic [7:0]  mq[N][$];
    logic [11:0] recv[$];
    int unsigned recv_cyc[$];
    logic [11:0] exp_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    int          viol = 0;
    int          mdl_last = N - 1;

    always #5 clk = ~clk;

    uart_rx_rr_collector #(
        .UART_NUM  (N),
        .BURST_MAX (BM),
        .CH_W      (CW)
    ) dut (
        .pcie_axi_clk       (clk),
        .sys_reset_n        (rst_n),
        .fifo_uart_rx_empty (empty),
        .fifo_uart_rx_rden  (rden),
        .uart_rx_data       (rx_data),
        .ch_enable          (en),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .m_data             (m_data),
        .m_chan             (m_chan),
        .m_last             (m_last),
        .busy               (busy)
    );

    // Show-ahead-free FIFOs: data valid the cycle after rden.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rden[i]) begin
                if (q[i].size() == 0) viol++;
                else rx_data[i*8 +: 8] <= q[i].pop_front();
            end
            empty[i] <= (q[i].size() == 0);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && m_valid && m_ready) begin
            recv.push_back({m_last, m_chan, m_data});
            recv_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push(input int ch, input int n);
        logic [7:0] b;
        for (int j = 0; j < n; j++) begin
            b = 8'($urandom);
            q[ch].push_back(b);
            mq[ch].push_back(b);
        end
    endtask

    // Whole bursts, round-robin after the last served channel.
    task automatic build_exp(input logic [N-1:0] mask);
        int ch;
        int take;
        while (1) begin
            ch = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mdl_last + k) % N;
                if (ch < 0 && mask[c] && mq[c].size() > 0) ch = c;
            end
            if (ch < 0) break;
            take = (mq[ch].size() < BM) ? mq[ch].size() : BM;
            for (int j = 0; j < take; j++) begin
                exp_q.push_back({(j == take - 1), 3'(ch), mq[ch].pop_front()});
            end
            mdl_last = ch;
        end
    endtask

    task automatic wait_recv(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (recv.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_count"}, recv.size(), n);
    endtask

    task automatic compare(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < recv.size()) ? 64'(recv[i]) : '1, exp_q[i]);
        end
        recv.delete();
        recv_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int t;
        rst_n   = 1'b0;
        en      = '1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_rden",  rden, 0);
        check("rst_data",  m_data, 0);
        check("rst_chan",  m_chan, 0);
        check("rst_last",  m_last, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Short burst on ch0
        push(0, 3);
        build_exp('1);
        wait_recv("ch0", 3, 100);
        if (recv_cyc.size() == 3) begin
            check("space01", recv_cyc[1] - recv_cyc[0], 3);
            check("space12", recv_cyc[2] - recv_cyc[1], 3);
        end
        compare("ch0");
        repeat (2) @(negedge clk);
        check("ch0_idle", busy, 0);

        // All channels, 40 bytes each
        for (int c = 0; c < N; c++) push(c, 40);
        build_exp('1);
        wait_recv("all", 240, 3000);
        compare("all");

        // Back-pressure stall
        m_ready = 1'b0;
        push(3, 2);
        build_exp('1);
        t = 0;
        while (!m_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("stall_valid", m_valid, 1);
            check("stall_hold", {m_last, m_chan, m_data}, exp_q[0]);
            check("stall_rden", rden, 0);
        end
        m_ready = 1'b1;
        wait_recv("stall", 2, 100);
        compare("stall");

        // Masked channel, then mid-burst disable
        en = 6'b111011;
        push(2, 5);
        push(4, 3);
        build_exp(en);
        wait_recv("mask", 3, 200);
        compare("mask");
        repeat (10) @(negedge clk);
        check("mask_none", recv.size(), 0);
        exp_q.push_back({1'b0, 3'd2, mq[2].pop_front()});
        exp_q.push_back({1'b1, 3'd2, mq[2].pop_front()});
        mdl_last = 2;
        en[2] = 1'b1;
        wait_recv("mid1", 1, 100);
        en[2] = 1'b0;
        wait_recv("mid2", 2, 100);
        repeat (10) @(negedge clk);
        check("mid_stop", recv.size(), 2);
        compare("mid");
        en = '1;
        build_exp('1);
        wait_recv("drain", 3, 100);
        compare("drain");

        // Reset while in CAP
        push(1, 2);
        t = 0;
        while (!rden[1] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cap_rd", rden[1], 1);
        @(negedge clk);
        rst_n = 1'b0;
        push(0, 1);
        void'(mq[1].pop_front());
        mdl_last = N - 1;
        @(negedge clk);
        check("crst_valid", m_valid, 0);
        check("crst_busy",  busy, 0);
        check("crst_rden",  rden, 0);
        rst_n = 1'b1;
        build_exp('1);
        wait_recv("crst", 2, 100);
        compare("crst");

        check("rden_on_empty", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
